srcnt_driver: RTL

SRCNT_DRIVER -- requirements
Module: srcnt_driver

---
 rtl/srcnt_driver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/srcnt_driver.sv
// srcnt_driver
// Serialises one WIDTH-bit word into a counterflow shift chain, MSB first.
// Each bit gets one slot of T_SETUP+T_HOLD cycles. In that slot:
//   - din pulses at the start of the slot when the bit is 1;
//   - clkin pulses T_SETUP cycles later whether the bit is 0 or 1.
// Rising edges on clkout_ret, returning from the far end of the chain, are
// counted while busy. At the end of the transfer, err reports whether the
// number of returned clocks was something other than WIDTH.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load_valid  in   word offered
//   load_data   in   [WIDTH] word to shift, sampled on accept
//   load_ready  out  high only while idle
//   din         out  data pulse to the chain input (registered)
//   clkin       out  shift-clock pulse to the chain clock input (registered)
//   clkout_ret  in   clock pulse returning from the far end of the chain
//   busy        out  high while slots are running or returns are drained
//   done        out  one-cycle end-of-transfer pulse
//   err         out  valid with done; returned clock count != WIDTH
`timescale 1ns/1ps
module srcnt_driver #(
  parameter int WIDTH       = 8,
  parameter int T_SETUP     = 8,
  parameter int T_HOLD      = 4,
  parameter int PULSE_W     = 2,
  parameter int RET_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             din,
  output logic             clkin,
  input  logic             clkout_ret,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int S   = T_SETUP + T_HOLD;
  localparam int SCW = $clog2(S + 1);
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int DCW = (RET_TIMEOUT > 1) ? $clog2(RET_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [SCW-1:0]   slot_q, slot_d;
  logic [BW-1:0]    bit_q, bit_d, bit_sel;
  logic [CW-1:0]    ret_q, ret_d;
  logic [DCW-1:0]   drain_q;
  logic             hit_q;
  logic             ret_prev_q;
  logic             din_q, clkin_q, done_q, err_q;
  logic [WIDTH-1:0] data_q;

  logic accept, ret_rise, slot_end, last_slot, din_d, clkin_d;

  // din/clkin are registered, so the values for the next cycle are
  // computed from the next slot position (slot_d, bit_d).
  always_comb begin
    accept    = load_valid && (state_q == IDLE);
    ret_rise  = clkout_ret && !ret_prev_q;
    slot_end  = (slot_q == SCW'(S - 1));
    last_slot = (bit_q == BW'(WIDTH - 1));
    slot_d    = slot_end ? '0 : slot_q + 1'b1;
    bit_d     = slot_end ? bit_q + 1'b1 : bit_q;
    bit_sel   = BW'(WIDTH - 1) - bit_d;
    din_d     = (slot_d < SCW'(PULSE_W)) && data_q[bit_sel];
    clkin_d   = (slot_d >= SCW'(T_SETUP)) && (slot_d < SCW'(T_SETUP + PULSE_W));
    ret_d     = ret_q;
    // Saturating count of returned edges; only meaningful while busy.
    if ((state_q == SLOT || state_q == DRAIN) && ret_rise && (ret_q != '1))
      ret_d = ret_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      bit_q      <= '0;
      ret_q      <= '0;
      drain_q    <= '0;
      hit_q      <= 1'b0;
      ret_prev_q <= 1'b0;
      din_q      <= 1'b0;
      clkin_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ret_prev_q <= clkout_ret;
      din_q      <= 1'b0;
      clkin_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      // The count-reached flag lags the counter by one cycle. This keeps
      // DRAIN open one extra cycle after the WIDTH-th edge, so a closely
      // following split or doubled pulse is still counted and flagged.
      hit_q      <= ((state_q == SLOT) || (state_q == DRAIN)) && (ret_q == CW'(WIDTH));
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SLOT;
            slot_q  <= '0;
            bit_q   <= '0;
            ret_q   <= '0;
            drain_q <= '0;
            din_q   <= load_data[WIDTH-1];
          end
        end
        SLOT: begin
          slot_q <= slot_d;
          bit_q  <= bit_d;
          ret_q  <= ret_d;
          if (slot_end && last_slot) begin
            state_q <= DRAIN;
          end else begin
            din_q   <= din_d;
            clkin_q <= clkin_d;
          end
        end
        DRAIN: begin
          ret_q   <= ret_d;
          drain_q <= drain_q + 1'b1;
          if (hit_q || (drain_q == DCW'(RET_TIMEOUT - 1))) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= (ret_d != CW'(WIDTH));
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Word storage carries no control meaning, so it is not reset.
  always_ff @(posedge clk) begin
    if (accept) data_q <= load_data;
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SLOT) || (state_q == DRAIN);
  assign din        = din_q;
  assign clkin      = clkin_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
